// File: rtl/ristretto_trap_ctrl.sv
// Trap control unit: sequences exception, interrupt and MRET events through
// CSR commit and fetch redirect. Optional macro: RISTRETTO_VECTORED_INT_EN.

package ristretto_trap_pkg;
    typedef struct packed {
        logic        mie;
        logic        mpie;
        logic        mpp;
        logic        meip;
        logic        msip;
        logic        mtip;
        logic        meie;
        logic        msie;
        logic        mtie;
        logic [31:0] mtvec;
        logic [31:0] mepc;
        logic [31:0] mcause;
        logic [31:0] mtval;
    } csr_ctrl_t;
endpackage

module ristretto_trap_ctrl
    import ristretto_trap_pkg::*;
#(
    parameter int unsigned DataWidth = 32,
    parameter int unsigned AddrWidth = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 exc_valid_i,
    input  logic [4:0]           exc_cause_i,
    input  logic [DataWidth-1:0] exc_tval_i,
    input  logic [AddrWidth-1:0] exc_pc_i,
    input  logic                 mret_i,
    input  logic                 irq_ok_i,
    input  logic [AddrWidth-1:0] next_pc_i,
    input  csr_ctrl_t            csr_control_i,
    output logic                 tcu_csr_we_o,
    output logic [DataWidth-1:0] csr_mcause_o,
    output logic [DataWidth-1:0] csr_mtval_o,
    output logic [AddrWidth-1:0] csr_mepc_o,
    output logic [2:0]           csr_trap_state_o,
    output logic [1:0]           priv_lvl_o,
    output logic                 stall_o,
    output logic                 flush_o,
    output logic                 redirect_valid_o,
    output logic [AddrWidth-1:0] redirect_pc_o,
    input  logic                 redirect_ready_i
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COMMIT,
        ST_REDIRECT
    } state_t;

    typedef enum logic [1:0] {
        EV_EXC,
        EV_IRQ,
        EV_MRET
    } event_t;

    localparam logic [1:0] PrivM = 2'b11;
    localparam logic [1:0] PrivU = 2'b00;

    state_t               r_state;
    event_t               r_event;
    logic [4:0]           r_cause;
    logic [DataWidth-1:0] r_tval;
    logic [AddrWidth-1:0] r_pc;
    logic [1:0]           r_priv;
    logic [AddrWidth-1:0] r_redirect_pc;

    state_t               w_state_nxt;
    event_t               w_event_nxt;
    logic [4:0]           w_cause_nxt;
    logic [DataWidth-1:0] w_tval_nxt;
    logic [AddrWidth-1:0] w_pc_nxt;
    logic [1:0]           w_priv_nxt;
    logic [AddrWidth-1:0] w_redirect_nxt;

    logic                 w_glob_en;
    logic                 w_irq_pend;
    logic [4:0]           w_irq_code;
    logic                 w_irq_take;
    logic [AddrWidth-1:0] w_mtvec;
    logic [AddrWidth-1:0] w_mtvec_base;
    logic [AddrWidth-1:0] w_trap_target;

    // Fixed source priority: external > software > timer.
    always_comb begin
        w_glob_en  = (r_priv == PrivM) ? csr_control_i.mie : 1'b1;
        w_irq_pend = 1'b0;
        w_irq_code = '0;
        if (csr_control_i.meip && csr_control_i.meie) begin
            w_irq_pend = 1'b1;
            w_irq_code = 5'd11;
        end else if (csr_control_i.msip && csr_control_i.msie) begin
            w_irq_pend = 1'b1;
            w_irq_code = 5'd3;
        end else if (csr_control_i.mtip && csr_control_i.mtie) begin
            w_irq_pend = 1'b1;
            w_irq_code = 5'd7;
        end
        w_irq_take = irq_ok_i && !exc_valid_i && w_glob_en && w_irq_pend;
    end

    always_comb begin
        w_mtvec       = AddrWidth'(csr_control_i.mtvec);
        w_mtvec_base  = {w_mtvec[AddrWidth-1:2], 2'b00};
        w_trap_target = w_mtvec_base;
`ifdef RISTRETTO_VECTORED_INT_EN
        if (r_event == EV_IRQ && w_mtvec[1:0] == 2'b01) begin
            w_trap_target = w_mtvec_base + (AddrWidth'(r_cause) << 2);
        end
`endif
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state       <= ST_IDLE;
            r_event       <= EV_EXC;
            r_cause       <= '0;
            r_tval        <= '0;
            r_pc          <= '0;
            r_priv        <= PrivM;
            r_redirect_pc <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_event       <= w_event_nxt;
            r_cause       <= w_cause_nxt;
            r_tval        <= w_tval_nxt;
            r_pc          <= w_pc_nxt;
            r_priv        <= w_priv_nxt;
            r_redirect_pc <= w_redirect_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_event_nxt      = r_event;
        w_cause_nxt      = r_cause;
        w_tval_nxt       = r_tval;
        w_pc_nxt         = r_pc;
        w_priv_nxt       = r_priv;
        w_redirect_nxt   = r_redirect_pc;
        tcu_csr_we_o     = 1'b0;
        flush_o          = 1'b0;
        csr_mcause_o     = '0;
        csr_mtval_o      = '0;
        csr_mepc_o       = '0;
        csr_trap_state_o = '0;
        redirect_valid_o = 1'b0;
        redirect_pc_o    = '0;
        stall_o          = (r_state != ST_IDLE);

        case (r_state)
            ST_IDLE: begin
                if (exc_valid_i) begin
                    w_state_nxt = ST_COMMIT;
                    w_event_nxt = EV_EXC;
                    w_cause_nxt = exc_cause_i;
                    w_tval_nxt  = exc_tval_i;
                    w_pc_nxt    = exc_pc_i;
                end else if (w_irq_take) begin
                    w_state_nxt = ST_COMMIT;
                    w_event_nxt = EV_IRQ;
                    w_cause_nxt = w_irq_code;
                    w_tval_nxt  = '0;
                    w_pc_nxt    = next_pc_i;
                end else if (mret_i) begin
                    w_state_nxt = ST_COMMIT;
                    w_event_nxt = EV_MRET;
                    w_cause_nxt = '0;
                    w_tval_nxt  = '0;
                    w_pc_nxt    = '0;
                end
            end

            ST_COMMIT: begin
                tcu_csr_we_o = 1'b1;
                flush_o      = 1'b1;
                w_state_nxt  = ST_REDIRECT;
                if (r_event == EV_MRET) begin
                    // Rewrite cause/tval/epc with their current values so the write strobe leaves them intact.
                    csr_mcause_o     = DataWidth'(csr_control_i.mcause);
                    csr_mtval_o      = DataWidth'(csr_control_i.mtval);
                    csr_mepc_o       = AddrWidth'(csr_control_i.mepc);
                    csr_trap_state_o = {csr_control_i.mpie, 1'b1, 1'b0};
                    w_priv_nxt       = csr_control_i.mpp ? PrivM : PrivU;
                    w_redirect_nxt   = AddrWidth'(csr_control_i.mepc);
                end else begin
                    csr_mcause_o     = (r_event == EV_IRQ) ? {1'b1, (DataWidth-1)'(r_cause)}
                                                           : DataWidth'(r_cause);
                    csr_mtval_o      = r_tval;
                    csr_mepc_o       = r_pc;
                    csr_trap_state_o = {1'b0, csr_control_i.mie, (r_priv == PrivM)};
                    w_priv_nxt       = PrivM;
                    w_redirect_nxt   = w_trap_target;
                end
            end

            ST_REDIRECT: begin
                redirect_valid_o = 1'b1;
                redirect_pc_o    = r_redirect_pc;
                if (redirect_ready_i) begin
                    w_state_nxt = ST_IDLE;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign priv_lvl_o = r_priv;

endmodule
